// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: memory bus, instruction hand-off and data-request signals for fetch_ctrl.
// master = fetch_ctrl side, slave = memory/executor side.
`default_nettype none

interface fetch_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_cmd;
  logic              mem_ready;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [ADDR_W-1:0] pc;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              dreq_valid;
  logic              dreq_write;
  logic [ADDR_W-1:0] dreq_addr;
  logic [DATA_W-1:0] dreq_wdata;
  logic              dresp_valid;
  logic [DATA_W-1:0] dresp_data;
  logic              halt;
  logic              bus_err;

  modport master (
    output mem_addr, mem_cmd, write_data, ir, ir_valid, pc,
           dresp_valid, dresp_data, bus_err,
    input  mem_ready, read_data, ir_ready, br_valid, br_target,
           dreq_valid, dreq_write, dreq_addr, dreq_wdata, halt
  );

  modport slave (
    input  mem_addr, mem_cmd, write_data, ir, ir_valid, pc,
           dresp_valid, dresp_data, bus_err,
    output mem_ready, read_data, ir_ready, br_valid, br_target,
           dreq_valid, dreq_write, dreq_addr, dreq_wdata, halt
  );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-port instruction fetch / data access sequencer with IR hand-off.
// Optional macro FETCH_TIMEOUT_EN adds a per-access wait limit that halts with bus_err.
`default_nettype none

module fetch_ctrl #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  wire logic    clk,
  input  wire logic    reset,
  fetch_ctrl_if.master bus
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic [1:0]        state_q,       state_d;
  logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic [DATA_W-1:0] ir_q,          ir_d;
  logic              dresp_valid_q, dresp_valid_d;
  logic [DATA_W-1:0] dresp_data_q,  dresp_data_d;

  logic [1:0]        mem_cmd_w;
  logic [ADDR_W-1:0] mem_addr_w;
  logic [DATA_W-1:0] write_data_w;

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic              access_w;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    dresp_valid_d = 1'b0;
    dresp_data_d  = dresp_data_q;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          ir_d       = bus.read_data;
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // A pending data request takes priority over consuming the instruction.
        if (bus.dreq_valid) begin
          state_d = S_DATA;
        end else if (bus.ir_ready) begin
          if (bus.br_valid) begin
            fetch_pc_d = bus.br_target;
          end
          state_d = bus.halt ? S_HALT : S_FETCH;
        end
      end
      S_DATA: begin
        if (bus.mem_ready) begin
          dresp_valid_d = 1'b1;
          if (!bus.dreq_write) begin
            dresp_data_d = bus.read_data;
          end
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

`ifdef FETCH_TIMEOUT_EN
    wait_d    = '0;
    bus_err_d = bus_err_q;
    access_w  = (state_q == S_FETCH) || (state_q == S_DATA);
    if (access_w && !bus.mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d       = S_HALT;
        bus_err_d     = 1'b1;
        ir_d          = ir_q;
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      dresp_valid_q <= 1'b0;
      dresp_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      dresp_valid_q <= dresp_valid_d;
      dresp_data_q  <= dresp_data_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.bus_err = bus_err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

  // reset gates the command directly so an in-flight access drops in the same cycle.
  always_comb begin
    mem_cmd_w    = MNONE;
    mem_addr_w   = fetch_pc_q;
    write_data_w = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: mem_cmd_w = MREAD;
        S_DATA: begin
          mem_addr_w = bus.dreq_addr;
          if (bus.dreq_write) begin
            mem_cmd_w    = MWRITE;
            write_data_w = bus.dreq_wdata;
          end else begin
            mem_cmd_w = MREAD;
          end
        end
        default: mem_cmd_w = MNONE;
      endcase
    end
  end

  assign bus.mem_cmd     = mem_cmd_w;
  assign bus.mem_addr    = mem_addr_w;
  assign bus.write_data  = write_data_w;
  assign bus.ir          = ir_q;
  assign bus.ir_valid    = (state_q == S_HOLD) || (state_q == S_DATA);
  assign bus.pc          = pc_q;
  assign bus.dresp_valid = dresp_valid_q;
  assign bus.dresp_data  = dresp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: vector table, directed corner sequences and a randomized scoreboard run for fetch_ctrl.
`default_nettype none

module tb_fetch_ctrl;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [15:0] mem [0:511];

  fetch_ctrl_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  fetch_ctrl #(
    .ADDR_W(9), .DATA_W(16), .RESET_PC(9'h000), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb bus.read_data = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (!reset && bus.mem_cmd == MWRITE && bus.mem_ready)
      mem[bus.mem_addr] <= bus.write_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_ready  = 1'b1;
    bus.ir_ready   = 1'b0;
    bus.br_valid   = 1'b0;
    bus.br_target  = '0;
    bus.dreq_valid = 1'b0;
    bus.dreq_write = 1'b0;
    bus.dreq_addr  = '0;
    bus.dreq_wdata = '0;
    bus.halt       = 1'b0;
  endtask

  // Leaves the bench at the negedge where reset is released (cycle 0 of the new run).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mem_cmd", 32'(bus.mem_cmd), 32'(MNONE));
    chk("rst_ir_valid", 32'(bus.ir_valid), 0);
    chk("rst_ir", 32'(bus.ir), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_write_data", 32'(bus.write_data), 0);
    chk("rst_dresp_valid", 32'(bus.dresp_valid), 0);
    chk("rst_dresp_data", 32'(bus.dresp_data), 0);
    chk("rst_bus_err", 32'(bus.bus_err), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        ir_ready;
    logic        br_valid;
    logic [8:0]  br_target;
    logic [1:0]  e_cmd;
    logic [8:0]  e_addr;
    logic        e_irv;
    logic [15:0] e_ir;
    logic [8:0]  e_pc;
  } vec_t;

  vec_t tbl [11];

  // Random-phase scoreboard state
  logic [8:0]  exp_fetch, fetched_pc, d_addr, br_t;
  logic [15:0] fetched_ir, d_wdata, exp_load;
  logic        dpend, d_write, resp_due, resp_write, brv;
  int          n_consumed, n_dataops, n_mread;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 7 + 16'h3000);
    mem[0]     = 16'hA001;
    mem[1]     = 16'hA002;
    mem[2]     = 16'hA003;
    mem[5]     = 16'hB005;
    mem[9'h1F0] = 16'hC1F0;
    mem[9'h1FF] = 16'hC1FF;
    idle_inputs();

    //            ir_rdy br  target  cmd     addr    irv  ir        pc
    tbl[0]  = '{1'b1, 1'b0, 9'h000, MREAD, 9'h000, 1'b0, 16'h0000, 9'h000};
    tbl[1]  = '{1'b1, 1'b0, 9'h000, MNONE, 9'h001, 1'b1, 16'hA001, 9'h000};
    tbl[2]  = '{1'b1, 1'b0, 9'h000, MREAD, 9'h001, 1'b0, 16'hA001, 9'h000};
    tbl[3]  = '{1'b1, 1'b0, 9'h000, MNONE, 9'h002, 1'b1, 16'hA002, 9'h001};
    tbl[4]  = '{1'b1, 1'b0, 9'h000, MREAD, 9'h002, 1'b0, 16'hA002, 9'h001};
    tbl[5]  = '{1'b1, 1'b1, 9'h1F0, MNONE, 9'h003, 1'b1, 16'hA003, 9'h002};
    tbl[6]  = '{1'b1, 1'b0, 9'h000, MREAD, 9'h1F0, 1'b0, 16'hA003, 9'h002};
    tbl[7]  = '{1'b1, 1'b1, 9'h1FF, MNONE, 9'h1F1, 1'b1, 16'hC1F0, 9'h1F0};
    tbl[8]  = '{1'b1, 1'b0, 9'h000, MREAD, 9'h1FF, 1'b0, 16'hC1F0, 9'h1F0};
    tbl[9]  = '{1'b1, 1'b0, 9'h000, MNONE, 9'h000, 1'b1, 16'hC1FF, 9'h1FF};
    tbl[10] = '{1'b1, 1'b0, 9'h000, MREAD, 9'h000, 1'b0, 16'hC1FF, 9'h1FF};

    // Vector table: sequential fetch, branch redirect, address wrap
    do_reset();
    for (int i = 0; i < 11; i++) begin
      bus.ir_ready  = tbl[i].ir_ready;
      bus.br_valid  = tbl[i].br_valid;
      bus.br_target = tbl[i].br_target;
      #1;
      chk($sformatf("vec%0d_cmd", i), 32'(bus.mem_cmd), 32'(tbl[i].e_cmd));
      chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d_irv", i), 32'(bus.ir_valid), 32'(tbl[i].e_irv));
      chk($sformatf("vec%0d_ir", i), 32'(bus.ir), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_pc", i), 32'(bus.pc), 32'(tbl[i].e_pc));
      @(negedge clk);
    end

    // Wait states on fetch of address 5
    idle_inputs();
    do_reset();
    #1;
    @(negedge clk);
    bus.ir_ready = 1'b1; bus.br_valid = 1'b1; bus.br_target = 9'h005;
    #1;
    @(negedge clk);
    bus.ir_ready = 1'b0; bus.br_valid = 1'b0; bus.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.mem_ready = 1'b1;
      #1;
      chk($sformatf("wait%0d_cmd", k), 32'(bus.mem_cmd), 32'(MREAD));
      chk($sformatf("wait%0d_addr", k), 32'(bus.mem_addr), 32'h5);
      chk($sformatf("wait%0d_irv", k), 32'(bus.ir_valid), 0);
      @(negedge clk);
    end
    #1;
    chk("wait_done_irv", 32'(bus.ir_valid), 1);
    chk("wait_done_ir", 32'(bus.ir), 32'hB005);
    chk("wait_done_pc", 32'(bus.pc), 32'h5);

    // Store then load at 0x040; ir_ready alongside dreq must be ignored
    bus.dreq_valid = 1'b1; bus.dreq_write = 1'b1; bus.dreq_addr = 9'h040;
    bus.dreq_wdata = 16'hBEEF; bus.ir_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("st_cmd", 32'(bus.mem_cmd), 32'(MWRITE));
    chk("st_addr", 32'(bus.mem_addr), 32'h040);
    chk("st_wdata", 32'(bus.write_data), 32'hBEEF);
    chk("st_irv", 32'(bus.ir_valid), 1);
    chk("st_ir", 32'(bus.ir), 32'hB005);
    @(negedge clk);
    bus.dreq_valid = 1'b0; bus.ir_ready = 1'b0;
    #1;
    chk("st_dresp_valid", 32'(bus.dresp_valid), 1);
    chk("st_back_hold_cmd", 32'(bus.mem_cmd), 32'(MNONE));
    chk("st_mem", 32'(mem[9'h040]), 32'hBEEF);
    chk("st_ir_kept", 32'(bus.ir), 32'hB005);
    @(negedge clk);
    #1;
    chk("st_dresp_pulse", 32'(bus.dresp_valid), 0);
    bus.dreq_valid = 1'b1; bus.dreq_write = 1'b0;
    @(negedge clk);
    #1;
    chk("ld_cmd", 32'(bus.mem_cmd), 32'(MREAD));
    chk("ld_addr", 32'(bus.mem_addr), 32'h040);
    chk("ld_wdata_zero", 32'(bus.write_data), 0);
    @(negedge clk);
    bus.dreq_valid = 1'b0;
    #1;
    chk("ld_dresp_valid", 32'(bus.dresp_valid), 1);
    chk("ld_dresp_data", 32'(bus.dresp_data), 32'hBEEF);

    // Reset during a stalled load
    @(negedge clk);
    bus.dreq_valid = 1'b1; bus.dreq_write = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rstd_pre_cmd", 32'(bus.mem_cmd), 32'(MREAD));
    reset = 1'b1;
    #1;
    chk("rstd_cmd", 32'(bus.mem_cmd), 32'(MNONE));
    chk("rstd_irv", 32'(bus.ir_valid), 0);
    @(negedge clk);
    reset = 1'b0; bus.dreq_valid = 1'b0; bus.mem_ready = 1'b1;
    #1;
    chk("rstd_first_cmd", 32'(bus.mem_cmd), 32'(MREAD));
    chk("rstd_first_addr", 32'(bus.mem_addr), 32'h000);

    // Halt combined with a branch: S_HALT is sticky
    @(negedge clk);
    bus.ir_ready = 1'b1; bus.halt = 1'b1; bus.br_valid = 1'b1; bus.br_target = 9'h010;
    @(negedge clk);
    bus.halt = 1'b0; bus.br_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("halt%0d_cmd", k), 32'(bus.mem_cmd), 32'(MNONE));
      chk($sformatf("halt%0d_irv", k), 32'(bus.ir_valid), 0);
      @(negedge clk);
    end
    idle_inputs();

`ifdef FETCH_TIMEOUT_EN
    begin
      int n_wait;
      n_wait = 0;
      do_reset();
      bus.mem_ready = 1'b0;
      for (int k = 0; k < 40; k++) begin
        #1;
        if (bus.mem_cmd != MREAD) break;
        n_wait++;
        @(negedge clk);
      end
      chk("to_wait_cycles", 32'(n_wait), 15);
      chk("to_cmd", 32'(bus.mem_cmd), 32'(MNONE));
      chk("to_bus_err", 32'(bus.bus_err), 1);
      chk("to_irv", 32'(bus.ir_valid), 0);
      idle_inputs();
    end
`endif

    // Randomized run against the scoreboard
    idle_inputs();
    do_reset();
    exp_fetch = 9'h000; dpend = 1'b0; resp_due = 1'b0; resp_write = 1'b0;
    fetched_ir = '0; fetched_pc = '0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    exp_load = '0; n_consumed = 0; n_dataops = 0; n_mread = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.ir_ready  = 1'($urandom_range(0, 1));
      brv           = ($urandom_range(0, 3) == 0);
      br_t          = 9'($urandom);
      bus.br_valid  = brv;
      bus.br_target = br_t;
      if (!dpend && $urandom_range(0, 7) == 0) begin
        dpend   = 1'b1;
        d_write = 1'($urandom_range(0, 1));
        d_addr  = 9'($urandom);
        d_wdata = 16'($urandom);
      end
      bus.dreq_valid = dpend;
      bus.dreq_write = d_write;
      bus.dreq_addr  = d_addr;
      bus.dreq_wdata = d_wdata;
      #1;
      chk("rnd_dresp_valid", 32'(bus.dresp_valid), 32'(resp_due));
      if (resp_due && !resp_write)
        chk("rnd_dresp_data", 32'(bus.dresp_data), 32'(exp_load));
      resp_due = 1'b0;
      if (bus.mem_cmd != MWRITE)
        chk("rnd_wdata_zero", 32'(bus.write_data), 0);
      if (!bus.ir_valid && bus.mem_cmd == MREAD) begin
        n_mread++;
        chk("rnd_fetch_addr", 32'(bus.mem_addr), 32'(exp_fetch));
        if (bus.mem_ready) begin
          fetched_ir = mem[bus.mem_addr];
          fetched_pc = bus.mem_addr;
        end
      end else if (bus.ir_valid && bus.mem_cmd != MNONE) begin
        chk("rnd_data_addr", 32'(bus.mem_addr), 32'(d_addr));
        chk("rnd_data_cmd", 32'(bus.mem_cmd), d_write ? 32'(MWRITE) : 32'(MREAD));
        if (d_write) chk("rnd_data_wdata", 32'(bus.write_data), 32'(d_wdata));
        chk("rnd_data_ir_kept", 32'(bus.ir), 32'(fetched_ir));
        if (bus.mem_ready) begin
          resp_due   = 1'b1;
          resp_write = d_write;
          exp_load   = mem[d_addr];
          dpend      = 1'b0;
          n_dataops++;
        end
      end else if (bus.ir_valid && bus.ir_ready && !dpend) begin
        n_consumed++;
        chk("rnd_consume_ir", 32'(bus.ir), 32'(fetched_ir));
        chk("rnd_consume_pc", 32'(bus.pc), 32'(fetched_pc));
        exp_fetch = brv ? br_t : 9'(fetched_pc + 9'd1);
      end
      @(negedge clk);
    end
    chk("rnd_progress_consumed", 32'(n_consumed > 200), 1);
    chk("rnd_progress_dataops", 32'(n_dataops > 20), 1);
    chk("rnd_progress_fetches", 32'(n_mread > 200), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
